// File: rtl/life_manager.sv
// life_manager: tracks remaining lives, the post-loss grace window and game over.
// All outputs come straight from flops; every response lands one clock after its input pulse.
module life_manager #(
    parameter int unsigned INIT_LIFE    = 3,
    parameter int unsigned MAX_LIFE     = 9,
    parameter int unsigned GRACE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       newGame,
    input  logic       ballLost,
    input  logic       extraLife,
    output logic [3:0] life,
    output logic       gameOver,
    output logic       respawnBall,
    output logic       graceActive
);

    localparam logic [1:0] ST_PLAY      = 2'd0;
    localparam logic [1:0] ST_GRACE     = 2'd1;
    localparam logic [1:0] ST_GAME_OVER = 2'd2;

    localparam logic [3:0] INIT_L  = 4'(INIT_LIFE);
    localparam logic [3:0] MAX_L   = 4'(MAX_LIFE);
    localparam logic [7:0] GRACE_N = 8'(GRACE_FRAMES);

    logic [1:0] state_q, state_d;
    logic [3:0] life_q, life_d;
    logic [7:0] cnt_q, cnt_d;
    logic       respawn_q, respawn_d;
    logic       over_q, grace_q;
    logic [3:0] life_inc;

    // Saturating increment shared by PLAY and GRACE.
    always_comb begin
        life_inc = (life_q >= MAX_L) ? MAX_L : life_q + 4'd1;
    end

    // Next-state decode; newGame overrides everything.
    always_comb begin
        state_d   = state_q;
        life_d    = life_q;
        cnt_d     = cnt_q;
        respawn_d = 1'b0;
        if (newGame) begin
            state_d   = ST_PLAY;
            life_d    = INIT_L;
            cnt_d     = 8'd0;
            respawn_d = 1'b1;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (ballLost && extraLife) begin
                        // Loss and award cancel out, but the ball still has to respawn.
                        state_d   = ST_GRACE;
                        cnt_d     = GRACE_N;
                        respawn_d = 1'b1;
                    end else if (ballLost) begin
                        if (life_q > 4'd1) begin
                            life_d    = life_q - 4'd1;
                            state_d   = ST_GRACE;
                            cnt_d     = GRACE_N;
                            respawn_d = 1'b1;
                        end else begin
                            life_d  = 4'd0;
                            state_d = ST_GAME_OVER;
                        end
                    end else if (extraLife) begin
                        life_d = life_inc;
                    end
                end
                ST_GRACE: begin
                    if (extraLife) begin
                        life_d = life_inc;
                    end
                    if (startOfFrame) begin
                        if (cnt_q > 8'd1) begin
                            cnt_d = cnt_q - 8'd1;
                        end else begin
                            cnt_d   = 8'd0;
                            state_d = ST_PLAY;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    life_d = 4'd0;
                end
                default: begin
                    state_d = ST_PLAY;
                    life_d  = INIT_L;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // State and registered status flags, all asynchronously reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_PLAY;
            life_q    <= INIT_L;
            cnt_q     <= 8'd0;
            respawn_q <= 1'b0;
            over_q    <= 1'b0;
            grace_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            life_q    <= life_d;
            cnt_q     <= cnt_d;
            respawn_q <= respawn_d;
            over_q    <= (state_d == ST_GAME_OVER);
            grace_q   <= (state_d == ST_GRACE);
        end
    end

    assign life        = life_q;
    assign gameOver    = over_q;
    assign respawnBall = respawn_q;
    assign graceActive = grace_q;

endmodule
